// File: rtl/tc_mult_pkg.sv
// tc_mult_pkg: shared defaults and stage bundle for the
// TrackletCalculator shared-multiplier arbiter.
package tc_mult_pkg;

  localparam int TC_NREQ = 4;
  localparam int TC_A_W  = 17;
  localparam int TC_B_W  = 18;
  localparam int TC_P_W  = 31;
  localparam int ID_W    = $clog2(TC_NREQ);

  typedef struct packed {
    logic                     v;
    logic [ID_W-1:0]          id;
    logic signed [TC_P_W-1:0] p;
  } mul_stage_t;

endpackage

// File: rtl/tc_mult_17s_18s.sv
// tc_mult_17s_18s: combinational signed a*b, low P_W bits.
// Ports: a (A_W signed), b (B_W signed), p (P_W signed, wraps).
module tc_mult_17s_18s
  import tc_mult_pkg::*;
#(
  parameter int A_W = TC_A_W,
  parameter int B_W = TC_B_W,
  parameter int P_W = TC_P_W
)(
  input  logic signed [A_W-1:0] a,
  input  logic signed [B_W-1:0] b,
  output logic signed [P_W-1:0] p
);

  logic signed [A_W+B_W-1:0] full;

  assign full = a * b;
  assign p    = full[P_W-1:0];

endmodule

// File: rtl/tc_mult_share_arbiter.sv
// tc_mult_share_arbiter: round-robin share of one 17s x 18s
// multiplier. Ports: ap_clk/ap_rst_n, req_valid/ready/a/b per
// requester (packed), res_valid/ready/id/p toward consumer.
module tc_mult_share_arbiter
  import tc_mult_pkg::*;
#(
  parameter int NREQ = TC_NREQ,
  parameter int A_W  = TC_A_W,
  parameter int B_W  = TC_B_W,
  parameter int P_W  = TC_P_W,
  parameter int PIPE = 2,
  localparam int IDW = $clog2(NREQ)
)(
  input  logic                   ap_clk,
  input  logic                   ap_rst_n,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*A_W-1:0]    req_a,
  input  logic [NREQ*B_W-1:0]    req_b,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [IDW-1:0]         res_id,
  output logic signed [P_W-1:0]  res_p
);

  // Returns {hit, index} of first valid at or after ptr.
  function automatic logic [IDW:0] rr_pick(
    input logic [NREQ-1:0] v,
    input logic [IDW-1:0]  ptr
  );
    logic [IDW:0] r;
    int           j;
    r = '0;
    for (int k = NREQ-1; k >= 0; k--) begin
      j = (int'(ptr) + k) % NREQ;
      if (v[j]) r = {1'b1, IDW'(j)};
    end
    return r;
  endfunction

  logic [IDW-1:0]        rr_ptr;
  logic                  adv;
  logic                  hit;
  logic                  xfer;
  logic [IDW-1:0]        gidx;
  logic                  s1_v;
  logic [IDW-1:0]        s1_id;
  logic signed [A_W-1:0] s1_a;
  logic signed [B_W-1:0] s1_b;
  logic signed [P_W-1:0] s1_p;
  mul_stage_t            s1_q;
  mul_stage_t            out_s;

  assign adv = !out_s.v || res_ready;

  assign {hit, gidx} = rr_pick(req_valid, rr_ptr);

  // Reset also masks the grant so nothing is accepted
  // while the pipeline is being cleared.
  assign xfer = adv && hit && ap_rst_n;

  always_comb begin
    req_ready = '0;
    if (xfer) req_ready[gidx] = 1'b1;
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      rr_ptr <= '0;
    end else if (xfer) begin
      rr_ptr <= (gidx == IDW'(NREQ-1)) ? '0 : gidx + 1'b1;
    end
  end

  // Operand data only reloads on a grant so outputs hold
  // their last values behind bubbles.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      s1_v  <= 1'b0;
      s1_id <= '0;
      s1_a  <= '0;
      s1_b  <= '0;
    end else if (adv) begin
      s1_v <= hit;
      if (hit) begin
        s1_id <= gidx;
        s1_a  <= req_a[gidx*A_W +: A_W];
        s1_b  <= req_b[gidx*B_W +: B_W];
      end
    end
  end

  tc_mult_17s_18s #(
    .A_W (A_W),
    .B_W (B_W),
    .P_W (P_W)
  ) u_mul (
    .a (s1_a),
    .b (s1_b),
    .p (s1_p)
  );

  assign s1_q = {s1_v, s1_id, s1_p};

  if (PIPE > 1) begin : g_pipe
    mul_stage_t stg [2:PIPE];
    mul_stage_t prv [2:PIPE];

    always_comb begin
      prv[2] = s1_q;
      for (int k = 3; k <= PIPE; k++) prv[k] = stg[k-1];
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
        for (int k = 2; k <= PIPE; k++) stg[k] <= '0;
      end else if (adv) begin
        for (int k = 2; k <= PIPE; k++) begin
          stg[k].v <= prv[k].v;
          if (prv[k].v) begin
            stg[k].id <= prv[k].id;
            stg[k].p  <= prv[k].p;
          end
        end
      end
    end

    assign out_s = stg[PIPE];
  end else begin : g_flat
    assign out_s = s1_q;
  end

  assign res_valid = out_s.v;
  assign res_id    = out_s.id;
  assign res_p     = out_s.p;

endmodule

// File: tb/tb_tc_mult_share_arbiter.sv
// tb_tc_mult_share_arbiter: directed steps with a scoreboard
// of truncated signed products for the shared multiplier.
module tb_tc_mult_share_arbiter;

  typedef struct {
    logic [1:0]  id;
    logic [30:0] p;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [67:0] req_a;
  logic [71:0] req_b;
  logic        res_valid;
  logic        res_ready;
  logic [1:0]  res_id;
  logic [30:0] res_p;

  exp_t sb[$];
  int   nvec = 0;
  int   nerr = 0;

  tc_mult_share_arbiter dut (
    .ap_clk    (clk),
    .ap_rst_n  (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_id    (res_id),
    .res_p     (res_p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [30:0] mdl(
    input logic [16:0] a,
    input logic [17:0] b
  );
    longint f;
    f = longint'($signed(a)) * longint'($signed(b));
    return f[30:0];
  endfunction

  task automatic chk(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(
    input int          i,
    input logic [16:0] a,
    input logic [17:0] b
  );
    req_a[i*17 +: 17] = a;
    req_b[i*18 +: 18] = b;
  endtask

  task automatic rnd_op(input int i);
    set_op(i, 17'($urandom), 18'($urandom));
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    sb.delete();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Scoreboard: push on accepted operands, pop on delivered
  always @(negedge clk) begin
    if (rst_n) begin
      chk("ready_onehot", 64'($countones(req_ready) <= 1), 64'd1);
      if (res_valid && res_ready) begin
        chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          chk("sb_id", 64'(res_id), 64'(sb[0].id));
          chk("sb_p", 64'(res_p), 64'(sb[0].p));
          void'(sb.pop_front());
        end
      end
      for (int i = 0; i < 4; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          sb.push_back('{id: 2'(i),
                         p: mdl(req_a[i*17 +: 17],
                                req_b[i*18 +: 18])});
        end
      end
    end
  end

  initial begin
    int  ep;
    logic stall;
    rst_n     = 1'b0;
    req_valid = 4'hF;
    req_a     = '0;
    req_b     = '0;
    res_ready = 1'b1;
    #3;
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_valid", 64'(res_valid), 64'd0);
    chk("rst_id", 64'(res_id), 64'd0);
    chk("rst_p", 64'(res_p), 64'd0);
    do_reset();

    // single request, latency and bubble hold
    set_op(0, 17'd3, -18'sd5);
    req_valid = 4'b0001;
    #1;
    chk("t1_ready", 64'(req_ready), 64'b0001);
    tick();
    req_valid = '0;
    chk("t1_lat0", 64'(res_valid), 64'd0);
    tick();
    chk("t1_valid", 64'(res_valid), 64'd1);
    chk("t1_p", 64'(res_p), 64'h7FFF_FFF1);
    chk("t1_id", 64'(res_id), 64'd0);
    tick();
    chk("t1_bubble", 64'(res_valid), 64'd0);
    chk("t1_hold", 64'(res_p), 64'h7FFF_FFF1);

    // extremes
    set_op(1, -17'sd65536, 18'sd131071);
    req_valid = 4'b0010;
    tick();
    set_op(1, -17'sd65536, -18'sd131072);
    tick();
    req_valid = '0;
    chk("t2_p_a", 64'(res_p), 64'h0001_0000);
    chk("t2_id_a", 64'(res_id), 64'd1);
    tick();
    chk("t2_p_b", 64'(res_p), 64'd0);
    tick();
    tick();

    // all valid, round robin, then 5-cycle stall
    do_reset();
    for (int i = 0; i < 4; i++) rnd_op(i);
    req_valid = 4'hF;
    ep = 0;
    for (int k = 0; k < 20; k++) begin
      stall     = (k >= 10 && k < 15);
      res_ready = !stall;
      #1;
      chk("rr_ready", 64'(req_ready),
          stall ? 64'd0 : 64'(4'b0001 << ep));
      if (k >= 2) chk("rr_valid", 64'(res_valid), 64'd1);
      if (k >= 2 && k < 10)
        chk("rr_id", 64'(res_id), 64'((k-2) % 4));
      if (stall && sb.size() != 0) begin
        chk("stall_id", 64'(res_id), 64'(sb[0].id));
        chk("stall_p", 64'(res_p), 64'(sb[0].p));
      end
      tick();
      if (!stall) begin
        rnd_op(ep);
        ep = (ep + 1) % 4;
      end
    end
    req_valid = '0;
    res_ready = 1'b1;
    tick();
    tick();
    tick();
    chk("rr_drain", 64'(sb.size()), 64'd0);

    // only 2 and 3 valid, pointer at 3
    do_reset();
    rnd_op(2);
    rnd_op(3);
    req_valid = 4'b0100;
    #1;
    chk("sv_first", 64'(req_ready), 64'b0100);
    tick();
    req_valid = 4'b1100;
    #1;
    chk("sv_g3a", 64'(req_ready), 64'b1000);
    tick();
    chk("sv_g2", 64'(req_ready), 64'b0100);
    tick();
    chk("sv_g3b", 64'(req_ready), 64'b1000);
    tick();
    req_valid = '0;
    tick();
    tick();
    tick();
    chk("sv_drain", 64'(sb.size()), 64'd0);

    // reset with two products in flight
    rnd_op(0);
    req_valid = 4'b0001;
    #1;
    chk("mr_ready", 64'(req_ready), 64'b0001);
    tick();
    rnd_op(0);
    tick();
    res_ready = 1'b0;
    req_valid = 4'hF;
    chk("mr_full", 64'(res_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mr_valid0", 64'(res_valid), 64'd0);
    chk("mr_ready0", 64'(req_ready), 64'd0);
    sb.delete();
    req_valid = '0;
    res_ready = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("mr_quiet", 64'(res_valid), 64'd0);
    end
    req_valid = 4'hF;
    #1;
    chk("mr_ptr0", 64'(req_ready), 64'b0001);
    tick();
    req_valid = '0;
    tick();
    tick();
    tick();
    chk("mr_drain", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
